// File: rtl/isa_decode_stage.sv
// Registered decode stage: turns the instruction-byte stream into one ALU micro-op per instruction.
// Holds a single output entry under back-pressure and captures the ADDI immediate byte.
module isa_decode_stage #(
    parameter int OPC_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPC_W-1:0] out_opcode,
    output logic             out_has_imm,
    output logic [7:0]       out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic [OPC_W-1:0]   r_opcode;
    logic               r_has_imm;
    logic [7:0]         r_imm;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_dec_code;
    logic               w_dec_illegal;
    logic               w_dec_addi;
    logic [OPC_W-1:0]   w_dec_opcode;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_load_imm;

    always_comb begin
        w_dec_code    = 4'h0;
        w_dec_illegal = 1'b0;
        w_dec_addi    = 1'b0;
        case (in_byte[7:4])
            4'h0: w_dec_code = in_byte[3:0];
            4'h2: w_dec_code = 4'h0;
            4'h3: w_dec_code = 4'h1;
            4'h4: w_dec_code = 4'h2;
            4'h5: w_dec_code = 4'h3;
            4'h6: w_dec_code = 4'h4;
            4'hE: w_dec_addi = 1'b1;
            4'hF: begin
                case (in_byte[3:0])
                    4'h6:    w_dec_code = 4'h5;
                    4'h7:    w_dec_code = 4'h6;
                    4'h8:    w_dec_code = 4'h7;
                    4'h9:    w_dec_code = 4'h8;
                    4'hA:    w_dec_code = 4'h9;
                    4'hC:    w_dec_code = 4'hA;
                    4'hE:    w_dec_code = 4'hB;
                    4'hD:    w_dec_code = 4'hC;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign w_dec_opcode = w_dec_illegal ? {OPC_W{1'b1}} : OPC_W'(w_dec_code);

    // Ready depends only on the output slot, so the same rule holds in both states.
    assign w_in_ready = !flush && (!r_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_load_imm = w_accept && (r_state == S_IMM);
    assign w_load     = w_load_imm || (w_accept && !w_dec_addi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_OP;
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_has_imm <= 1'b0;
            r_imm     <= 8'h00;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_state <= S_OP;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_state == S_IMM) begin
                    r_state <= S_OP;
                end else if (w_dec_addi) begin
                    r_state <= S_IMM;
                end
            end

            if (w_load) begin
                r_valid <= 1'b1;
                if (w_load_imm) begin
                    r_opcode  <= '0;
                    r_has_imm <= 1'b1;
                    r_imm     <= in_byte;
                    r_illegal <= 1'b0;
                end else begin
                    r_opcode  <= w_dec_opcode;
                    r_has_imm <= 1'b0;
                    r_imm     <= 8'h00;
                    r_illegal <= w_dec_illegal;
                    if (w_dec_illegal && (r_cnt != {CNT_W{1'b1}})) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid;
    assign out_opcode  = r_opcode;
    assign out_has_imm = r_has_imm;
    assign out_imm     = r_imm;
    assign out_illegal = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: doc/isa_decode_stage.md
Name: isa_decode_stage

Overview:
- Registered, handshaked successor to the combinational ISA-to-ALU-opcode decoder.
- Sits between the instruction-byte fetch stream and the execute stage, and emits one decoded micro-op per instruction.
- New over the combinational decoder:
  - ADDI is a two-byte instruction; its immediate byte is captured here.
  - Illegal encodings produce a defined opcode and a flag instead of X.
  - A saturating illegal-instruction counter is provided.
  - A synchronous flush is provided.

Parameters:
OPC_W, 4, ALU opcode width; must be >= 4; codes are zero-extended to OPC_W
CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush: drop held output and any pending ADDI
in_valid  in  1  instruction byte valid
in_ready  out  1  stage accepts the byte this cycle
in_byte  in  8  instruction or immediate byte
out_valid  out  1  decoded micro-op valid
out_ready  in  1  execute stage accepts the micro-op
out_opcode  out  OPC_W  ALU opcode
out_has_imm  out  1  micro-op carries an immediate (ADDI)
out_imm  out  8  immediate byte; 0 when out_has_imm=0
out_illegal  out  1  byte was not a legal encoding
illegal_cnt  out  CNT_W  count of illegal micro-ops emitted, saturating

Behaviour:
- Decode table (x = don't care; values are out_opcode):
  - 0x0x LDA -> {0, low nibble}
  - 0x2x ADD -> 0
  - 0x3x SUB -> 1
  - 0x4x AND -> 2
  - 0x5x OR -> 3
  - 0x6x XOR -> 4
  - 0xEx ADDI -> 0, two-byte
  - 0xF6 SHL -> 5
  - 0xF7 SHR -> 6
  - 0xF8 SHL4 -> 7
  - 0xF9 ROL -> 8
  - 0xFA ROR -> 9
  - 0xFC DEC -> A
  - 0xFE INV -> B
  - 0xFD CLR -> C
  - All other bytes: illegal, out_opcode = all ones, out_illegal = 1.
- FSM states:
  - S_OP: expecting an opcode byte.
  - S_IMM: expecting the ADDI immediate byte.
- Output register: a single entry, held stable while out_valid && !out_ready.
- in_ready = !flush && (!out_valid || out_ready). Same in both states; combinational path from out_ready is allowed.
- Transitions:
  - S_OP, byte accepted, non-ADDI: load output register next edge (latency 1); stay in S_OP.
  - S_OP, byte accepted, ADDI (0xEx): go to S_IMM; output register is not loaded.
    - If the old micro-op is consumed this cycle, out_valid drops.
  - S_IMM, byte accepted: load opcode 0, out_has_imm = 1, out_imm = byte; return to S_OP.
    - Any byte value is legal as an immediate.
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a new micro-op loads in the same cycle.
  - Sustained throughput is one instruction per cycle with out_ready held high. ADDI costs 2 input cycles.
- Illegal counter:
  - Increments by 1 on each edge that loads an illegal micro-op.
  - Holds at all ones.
  - Not affected by flush.
- Flush (synchronous):
  - Next edge: out_valid = 0 and state = S_OP; a pending ADDI opcode is discarded.
  - in_ready = 0 during the flush cycle, so the presented byte is not consumed.
  - Flush wins over all other events in the same cycle.
- Reset (async, rst_n low), effective immediately, including mid-ADDI:
  - state = S_OP
  - out_valid = 0, out_opcode = 0, out_has_imm = 0, out_imm = 0, out_illegal = 0
  - illegal_cnt = 0
- Data fields of an idle output register hold their last values. Only out_valid qualifies them.

Test Plan:
- Reset, then in_valid=1 with byte 0x35 and out_ready=1 -> one cycle later out_valid=1, opcode=1, illegal=0, has_imm=0.
- Stream 0x07, 0xF9, 0xFD back-to-back with out_ready=1 -> micro-ops with opcodes 7, 8, C on consecutive cycles; in_ready stays 1.
- Bytes 0xE2 then 0x5A -> exactly one micro-op: opcode=0, has_imm=1, imm=0x5A. No output after the first byte.
- Byte 0xF0 -> opcode=F, illegal=1, illegal_cnt=1. With CNT_W=2, send 5 illegal bytes -> illegal_cnt saturates at 3.
- Back-pressure: out_ready=0 while 0x41 is held -> micro-op (opcode 2) stays stable and in_ready=0. Then raise out_ready together with byte 0x62 -> next micro-op has opcode 4 with no bubble.
- Send 0xE0, then assert flush with 0x20 presented -> no output, state S_OP, 0x20 not consumed. Next 0x20 yields opcode 0. Asserting rst_n low mid-ADDI also clears all outputs immediately.
